// File: rtl/battle_ctrl.sv
// battle_ctrl: turn sequencer for the battle datapath.
// Loads HP, waits for a move, resolves both attacks in speed order, handles
// faints/party switching and ends the battle in VICTORY or LOSS.
// Optional macro TURN_LIMIT_EN compiles in the DRAW state and MAX_TURNS check.
module battle_ctrl #(
   parameter int HP_W      = 8,
   parameter int PARTY     = 3,
   parameter int MAX_TURNS = 50,
   localparam int SLOT_W   = (PARTY > 1) ? $clog2(PARTY) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic              p_first,
   input  logic [HP_W-1:0]   p_hp,
   input  logic [HP_W-1:0]   ai_hp,
   output logic              load_p_hp,
   output logic              load_ai_hp,
   output logic              apply_p_damage,
   output logic              apply_ai_damage,
   output logic              active_trainer,
   output logic              target,
   output logic [SLOT_W-1:0] p_slot,
   output logic [SLOT_W-1:0] ai_slot,
   output logic [7:0]        turn_count,
   output logic              victory,
   output logic              loss,
   output logic              draw,
   output logic              busy,
   output logic [3:0]        state
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD_HP = 4'd1,
      S_WAIT    = 4'd2,
      S_ATTACK1 = 4'd3,
      S_CHECK1  = 4'd4,
      S_ATTACK2 = 4'd5,
      S_CHECK2  = 4'd6,
      S_VICTORY = 4'd7,
      S_LOSS    = 4'd8,
      S_DRAW    = 4'd9
   } state_t;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PARTY - 1);
   localparam logic [7:0]        MAX_T8    = 8'(MAX_TURNS);

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] p_slot_q, p_slot_d;
   logic [SLOT_W-1:0] ai_slot_q, ai_slot_d;
   logic [7:0]        turn_q, turn_d;
   logic              first_is_ai_q, first_is_ai_d;

   // CHECK1 looks at whoever the first attacker hit; CHECK2 at the other side
   logic       tgt_ai;
   logic       tgt_zero;
   logic       tgt_last;
   logic [7:0] turn_inc;

   // Target selection and saturating turn increment for the CHECK states
   always_comb begin
      tgt_ai   = (state_q == S_CHECK1) ? ~first_is_ai_q : first_is_ai_q;
      tgt_zero = tgt_ai ? (ai_hp == '0) : (p_hp == '0);
      tgt_last = tgt_ai ? (ai_slot_q == LAST_SLOT) : (p_slot_q == LAST_SLOT);
      turn_inc = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
   end

   // State register and turn bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         p_slot_q      <= '0;
         ai_slot_q     <= '0;
         turn_q        <= '0;
         first_is_ai_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_slot_q      <= p_slot_d;
         ai_slot_q     <= ai_slot_d;
         turn_q        <= turn_d;
         first_is_ai_q <= first_is_ai_d;
      end
   end

   // Next-state: turn sequencing, faint handling, terminal states
   always_comb begin
      state_d       = state_q;
      p_slot_d      = p_slot_q;
      ai_slot_d     = ai_slot_q;
      turn_d        = turn_q;
      first_is_ai_d = first_is_ai_q;
      case (state_q)
         S_IDLE: if (go) begin
            p_slot_d  = '0;
            ai_slot_d = '0;
            turn_d    = '0;
            state_d   = S_LOAD_HP;
         end
         S_LOAD_HP: state_d = S_WAIT;
         S_WAIT: if (go) begin
            first_is_ai_d = ~p_first;
            state_d       = S_ATTACK1;
         end
         S_ATTACK1: state_d = S_CHECK1;
         S_ATTACK2: state_d = S_CHECK2;
         S_CHECK1, S_CHECK2: begin
            if (!tgt_zero) begin
               if (state_q == S_CHECK1) begin
                  state_d = S_ATTACK2;
               end else begin
                  turn_d  = turn_inc;
                  state_d = S_WAIT;
`ifdef TURN_LIMIT_EN
                  if (turn_inc >= MAX_T8) state_d = S_DRAW;
`endif
               end
            end else if (tgt_last) begin
               // last Pokemon on that side fainted: the battle is over
               state_d = tgt_ai ? S_VICTORY : S_LOSS;
            end else begin
               // send in the next party member; remaining attack is dropped
               if (tgt_ai) ai_slot_d = ai_slot_q + SLOT_W'(1);
               else        p_slot_d  = p_slot_q + SLOT_W'(1);
               turn_d  = turn_inc;
               state_d = S_LOAD_HP;
            end
         end
         S_VICTORY, S_LOSS, S_DRAW: if (go) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output decode from registered state
   always_comb begin
      load_p_hp       = 1'b0;
      load_ai_hp      = 1'b0;
      apply_p_damage  = 1'b0;
      apply_ai_damage = 1'b0;
      active_trainer  = 1'b0;
      target          = 1'b0;
      case (state_q)
         S_LOAD_HP: begin
            load_p_hp  = 1'b1;
            load_ai_hp = 1'b1;
         end
         S_ATTACK1, S_ATTACK2: begin
            // ATTACK2 uses the opposite attacker of ATTACK1
            active_trainer  = (state_q == S_ATTACK1) ? first_is_ai_q : ~first_is_ai_q;
            target          = ~active_trainer;
            apply_p_damage  = active_trainer;
            apply_ai_damage = ~active_trainer;
         end
         default: ;
      endcase
   end

   assign p_slot     = p_slot_q;
   assign ai_slot    = ai_slot_q;
   assign turn_count = turn_q;
   assign victory    = (state_q == S_VICTORY);
   assign loss       = (state_q == S_LOSS);
   assign state      = state_q;
   assign busy       = !(state_q inside {S_IDLE, S_WAIT, S_VICTORY, S_LOSS, S_DRAW});

`ifdef TURN_LIMIT_EN
   assign draw = (state_q == S_DRAW);
`else
   // turn limit not built: the limit value is intentionally left unused
   logic [7:0] unused_max;
   assign unused_max = MAX_T8;
   assign draw       = 1'b0;
`endif

endmodule

// File: tb/tb_battle_ctrl.sv
// Scoreboard bench for battle_ctrl: each driven cycle pushes the expected
// post-edge snapshot, which is popped and compared once the DUT has updated.
module tb_battle_ctrl;
   localparam int HP_W = 8, PARTY = 3, MAX_TURNS = 3;

   logic       clk = 1'b0, reset_n = 1'b0, go = 1'b0, p_first = 1'b0;
   logic [7:0] p_hp = 8'd20, ai_hp = 8'd20;
   logic       load_p_hp, load_ai_hp, apply_p_damage, apply_ai_damage;
   logic       active_trainer, target, victory, loss, draw, busy;
   logic [1:0] p_slot, ai_slot;
   logic [7:0] turn_count;
   logic [3:0] state;

   battle_ctrl #(.HP_W(HP_W), .PARTY(PARTY), .MAX_TURNS(MAX_TURNS)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .p_first(p_first),
      .p_hp(p_hp), .ai_hp(ai_hp),
      .load_p_hp(load_p_hp), .load_ai_hp(load_ai_hp),
      .apply_p_damage(apply_p_damage), .apply_ai_damage(apply_ai_damage),
      .active_trainer(active_trainer), .target(target),
      .p_slot(p_slot), .ai_slot(ai_slot), .turn_count(turn_count),
      .victory(victory), .loss(loss), .draw(draw), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   // strb = {load_p, load_ai, apply_p, apply_ai}; at = {active_trainer, target}
   // fl = {victory, loss, draw, busy}
   typedef struct packed {
      logic [3:0] st;
      logic [3:0] strb;
      logic [1:0] at;
      logic [1:0] ps;
      logic [1:0] as;
      logic [7:0] tc;
      logic [3:0] fl;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic exp_t ex(input logic [3:0] st, input logic [3:0] strb,
                               input logic [1:0] at, input logic [1:0] ps,
                               input logic [1:0] as, input logic [7:0] tc,
                               input logic [3:0] fl);
      ex = '{st: st, strb: strb, at: at, ps: ps, as: as, tc: tc, fl: fl};
   endfunction

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, ".st"},   32'(state), 32'(e.st));
      chk({tag, ".strb"}, 32'({load_p_hp, load_ai_hp, apply_p_damage, apply_ai_damage}), 32'(e.strb));
      chk({tag, ".at"},   32'({active_trainer, target}), 32'(e.at));
      chk({tag, ".slot"}, 32'({p_slot, ai_slot}), 32'({e.ps, e.as}));
      chk({tag, ".tc"},   32'(turn_count), 32'(e.tc));
      chk({tag, ".fl"},   32'({victory, loss, draw, busy}), 32'(e.fl));
   endtask

   // drive one cycle of inputs, expect the given snapshot after the edge
   task automatic tick(input logic g, input logic pf, input logic [7:0] ph,
                       input logic [7:0] ah, input exp_t e, input string tag);
      go = g; p_first = pf; p_hp = ph; ai_hp = ah;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      pop_cmp(tag);
   endtask

   // full turn without faints; tc is the count before the turn
   task automatic turn_ok(input logic pf, input logic [1:0] ps, input logic [1:0] as,
                          input logic [7:0] tc, input logic [3:0] end_st,
                          input logic [3:0] end_fl, input string tag);
      logic [3:0] s1, s2;
      logic [1:0] a1, a2;
      s1 = pf ? 4'b0001 : 4'b0010;  a1 = pf ? 2'b01 : 2'b10;
      s2 = pf ? 4'b0010 : 4'b0001;  a2 = pf ? 2'b10 : 2'b01;
      tick(1, pf, 20, 20, ex(3, s1, a1, ps, as, tc, 4'b0001), {tag, ".a1"});
      tick(0, pf, 20, 20, ex(4, 0, 0, ps, as, tc, 4'b0001), {tag, ".c1"});
      tick(0, pf, 20, 20, ex(5, s2, a2, ps, as, tc, 4'b0001), {tag, ".a2"});
      tick(0, pf, 20, 20, ex(6, 0, 0, ps, as, tc, 4'b0001), {tag, ".c2"});
      tick(0, pf, 20, 20, ex(end_st, 0, 0, ps, as, tc + 8'd1, end_fl), {tag, ".end"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #12;
      sb_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
      pop_cmp("rst");
      @(negedge clk); reset_n = 1'b1;

      // start battle
      tick(1, 1, 20, 20, ex(1, 4'b1100, 0, 0, 0, 0, 4'b0001), "ld0");
      tick(0, 1, 20, 20, ex(2, 0, 0, 0, 0, 0, 0), "wm0");

      // normal turn, player first
      turn_ok(1, 0, 0, 0, 2, 0, "t1");

      // AI faints in CHECK1 (slot 0): ATTACK2 skipped, reload
      tick(1, 1, 20, 20, ex(3, 4'b0001, 2'b01, 0, 0, 1, 4'b0001), "f.a1");
      tick(0, 1, 20, 20, ex(4, 0, 0, 0, 0, 1, 4'b0001), "f.c1");
      tick(0, 1, 20, 0,  ex(1, 4'b1100, 0, 0, 1, 2, 4'b0001), "f.ld");
      tick(0, 1, 20, 20, ex(2, 0, 0, 0, 1, 2, 0), "f.wm");

      // reset asserted mid-ATTACK2
      tick(1, 1, 20, 20, ex(3, 4'b0001, 2'b01, 0, 1, 2, 4'b0001), "r.a1");
      tick(0, 1, 20, 20, ex(4, 0, 0, 0, 1, 2, 4'b0001), "r.c1");
      tick(0, 1, 20, 20, ex(5, 4'b0010, 2'b10, 0, 1, 2, 4'b0001), "r.a2");
      reset_n = 1'b0;
      #1;
      sb_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
      pop_cmp("rst_mid");
      @(negedge clk); reset_n = 1'b1;

      // victory: AI loses all three
      tick(1, 1, 20, 20, ex(1, 4'b1100, 0, 0, 0, 0, 4'b0001), "v.ld");
      tick(0, 1, 20, 20, ex(2, 0, 0, 0, 0, 0, 0), "v.wm");
      for (int k = 0; k < 2; k++) begin
         tick(1, 1, 20, 20, ex(3, 4'b0001, 2'b01, 0, 2'(k), 8'(k), 4'b0001), "v.a1");
         tick(0, 1, 20, 20, ex(4, 0, 0, 0, 2'(k), 8'(k), 4'b0001), "v.c1");
         tick(0, 1, 20, 0,  ex(1, 4'b1100, 0, 0, 2'(k + 1), 8'(k + 1), 4'b0001), "v.ld");
         tick(0, 1, 20, 20, ex(2, 0, 0, 0, 2'(k + 1), 8'(k + 1), 0), "v.wm");
      end
      tick(1, 1, 20, 20, ex(3, 4'b0001, 2'b01, 0, 2, 2, 4'b0001), "v.a1l");
      tick(0, 1, 20, 20, ex(4, 0, 0, 0, 2, 2, 4'b0001), "v.c1l");
      tick(0, 1, 20, 0,  ex(7, 0, 0, 0, 2, 2, 4'b1000), "vic");
      tick(0, 1, 20, 20, ex(7, 0, 0, 0, 2, 2, 4'b1000), "vic.hold");
      tick(1, 1, 20, 20, ex(0, 0, 0, 0, 2, 2, 0), "vic.idle");

      // loss: player loses all three (CHECK1, CHECK2, CHECK1)
      tick(1, 0, 20, 20, ex(1, 4'b1100, 0, 0, 0, 0, 4'b0001), "l.ld");
      tick(0, 0, 20, 20, ex(2, 0, 0, 0, 0, 0, 0), "l.wm");
      tick(1, 0, 20, 20, ex(3, 4'b0010, 2'b10, 0, 0, 0, 4'b0001), "l1.a1");
      tick(0, 0, 20, 20, ex(4, 0, 0, 0, 0, 0, 4'b0001), "l1.c1");
      tick(0, 0, 0, 20,  ex(1, 4'b1100, 0, 1, 0, 1, 4'b0001), "l1.ld");
      tick(0, 0, 20, 20, ex(2, 0, 0, 1, 0, 1, 0), "l1.wm");
      tick(1, 1, 20, 20, ex(3, 4'b0001, 2'b01, 1, 0, 1, 4'b0001), "l2.a1");
      tick(0, 1, 20, 20, ex(4, 0, 0, 1, 0, 1, 4'b0001), "l2.c1");
      tick(0, 1, 20, 20, ex(5, 4'b0010, 2'b10, 1, 0, 1, 4'b0001), "l2.a2");
      tick(0, 1, 20, 20, ex(6, 0, 0, 1, 0, 1, 4'b0001), "l2.c2");
      tick(0, 1, 0, 20,  ex(1, 4'b1100, 0, 2, 0, 2, 4'b0001), "l2.ld");
      tick(0, 1, 20, 20, ex(2, 0, 0, 2, 0, 2, 0), "l2.wm");
      tick(1, 0, 20, 20, ex(3, 4'b0010, 2'b10, 2, 0, 2, 4'b0001), "l3.a1");
      tick(0, 0, 20, 20, ex(4, 0, 0, 2, 0, 2, 4'b0001), "l3.c1");
      tick(0, 0, 0, 20,  ex(8, 0, 0, 2, 0, 2, 4'b0100), "loss");
      tick(0, 0, 0, 20,  ex(8, 0, 0, 2, 0, 2, 4'b0100), "loss.hold");
      tick(1, 0, 20, 20, ex(0, 0, 0, 2, 0, 2, 0), "loss.idle");

      // turn limit (MAX_TURNS=3)
      tick(1, 1, 20, 20, ex(1, 4'b1100, 0, 0, 0, 0, 4'b0001), "d.ld");
      tick(0, 1, 20, 20, ex(2, 0, 0, 0, 0, 0, 0), "d.wm");
      turn_ok(1, 0, 0, 0, 2, 0, "d1");
      turn_ok(0, 0, 0, 1, 2, 0, "d2");
`ifdef TURN_LIMIT_EN
      turn_ok(1, 0, 0, 2, 9, 4'b0010, "d3");
      tick(0, 1, 20, 20, ex(9, 0, 0, 0, 0, 3, 4'b0010), "draw.hold");
      tick(1, 1, 20, 20, ex(0, 0, 0, 0, 0, 3, 0), "draw.idle");
`else
      turn_ok(1, 0, 0, 2, 2, 0, "d3");
      turn_ok(0, 0, 0, 3, 2, 0, "d4");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/battle_ctrl.md
# battle_ctrl

Parametrised turn controller for the battle datapath. It sequences full turns: load HP, wait for a move, resolve two attacks in speed order, handle faints and party switching, and declare victory, loss or (optionally) a draw. It sits between the board-level `go` key and the HP/damage datapath, and drives that datapath's load and apply strobes plus the active-slot indices.

## Interface
Parameters:
- `HP_W`, default 8: width of HP values from the datapath.
- `PARTY`, default 3: Pokémon per trainer, legal range 1..8. Localparam `SLOT_W` = `$clog2(PARTY)`, minimum 1.
- `MAX_TURNS`, default 50: turn limit, 1..255. Used only with `TURN_LIMIT_EN`.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: advance request, level-sampled in IDLE, WAIT_MOVE and terminal states.
- `p_first` in 1: 1 = player moves first this turn. Sampled with the accepted `go` in WAIT_MOVE.
- `p_hp` in `HP_W`: current HP of the player's active Pokémon.
- `ai_hp` in `HP_W`: current HP of the AI's active Pokémon.
- `load_p_hp`, `load_ai_hp` out 1: load the active slot's stored HP into the datapath.
- `apply_p_damage`, `apply_ai_damage` out 1: one-cycle damage strobes.
- `active_trainer` out 1: 0 = player attacking, 1 = AI attacking.
- `target` out 1: 0 = player's Pokémon targeted, 1 = AI's Pokémon targeted.
- `p_slot`, `ai_slot` out `SLOT_W`: active party index for each side.
- `turn_count` out 8: completed turns, saturating at 255.
- `victory`, `loss`, `draw` out 1: terminal flags.
- `busy` out 1: high in every state except IDLE, WAIT_MOVE and the terminal states.
- `state` out 4: current state encoding, for debug LEDs.

## Operation
State encodings: IDLE=0, LOAD_HP=1, WAIT_MOVE=2, ATTACK1=3, CHECK1=4, ATTACK2=5, CHECK2=6, VICTORY=7, LOSS=8, DRAW=9.

- **Reset:** `state`=IDLE; slots=0; `turn_count`=0; `first_is_ai`=0; all outputs 0.
- **IDLE:** on `go`, clear both slots and `turn_count`, then go to LOAD_HP.
- **LOAD_HP:** assert `load_p_hp` and `load_ai_hp` for exactly one cycle, then go to WAIT_MOVE.
- **WAIT_MOVE:** on `go`, register `first_is_ai = ~p_first`, then go to ATTACK1.
- **ATTACK1:** the first attacker strikes.
  - Player attacking: `active_trainer`=0, `target`=1, `apply_ai_damage`=1.
  - AI attacking: `active_trainer`=1, `target`=0, `apply_p_damage`=1.
  - Then go to CHECK1.
- **ATTACK2:** the second attacker strikes, with the same output mapping. Then go to CHECK2.
- **CHECK1 / CHECK2:** sample the target's HP. Zero means `== 0`; HP is unsigned.
  - Target HP nonzero: CHECK1 goes to ATTACK2; CHECK2 increments `turn_count` and goes to WAIT_MOVE. With `TURN_LIMIT_EN`, CHECK2 goes to DRAW instead if the incremented count is ≥ `MAX_TURNS`.
  - Target HP zero and target slot == `PARTY`-1: go to VICTORY if the AI fainted, LOSS if the player fainted.
  - Target HP zero otherwise: increment the target's slot and `turn_count`, then go to LOAD_HP. Any pending ATTACK2 is skipped.
  - The turn limit is checked only on the CHECK2 nonzero path. A faint never produces a draw.
- **VICTORY / LOSS / DRAW:** hold the matching flag high. `go` returns to IDLE; slots and count are held until IDLE's `go`.
- **Counter:** `turn_count` saturates at 255 and never wraps.
- **Outputs:** all outputs are decoded from registered state and registers only (Moore). Strobes are never asserted in any other state.

## Timing
- **Reset:** asynchronous assert, with immediate effect on all outputs. Deassertion is synchronised externally.
- **Reset mid-turn:** returns to IDLE with no further strobes.
- **Move latency:** `go` is accepted in WAIT_MOVE at edge N. ATTACK1 strobe is high in cycle N+1; CHECK1 samples HP in cycle N+2; ATTACK2 in N+3; CHECK2 in N+4; back in WAIT_MOVE at N+5.
- **Datapath contract:** the damage strobe updates the HP register at the end of the ATTACK cycle, so the CHECK cycle observes post-damage HP.
- **`go` level:** it is not edge-detected. A `go` held through WAIT_MOVE re-triggers a new turn immediately after CHECK2, by design; the debounced pulse comes from the board wrapper.
- **Load strobes:** asserted only in LOAD_HP, for exactly one cycle, one cycle after each faint.

## Configuration
- `TURN_LIMIT_EN` defined: the DRAW state and `MAX_TURNS` check are compiled in.
- `TURN_LIMIT_EN` undefined: DRAW is unreachable, the `draw` port is tied 0, and battles continue until a faint ends them.

## Test plan
- **Reset:** assert `reset_n`=0 mid-ATTACK2 → next sample shows `state`=0, every output 0, slots 0, `turn_count` 0.
- **Normal turn:** `PARTY`=3, `p_first`=1, `ai_hp`=20 and `p_hp`=20 after damage, `go` at edge N → `apply_ai_damage` in N+1, `apply_p_damage` in N+3, `state`=2 and `turn_count`=1 at N+5.
- **AI faint, not last:** AI faints in CHECK1 with `ai_slot`=0 → no ATTACK2, `ai_slot`=1, `load_ai_hp`/`load_p_hp` high for one cycle, then WAIT_MOVE.
- **Victory:** `ai_slot`=2 and `ai_hp`=0 at CHECK → `victory`=1 held. Then `go` → `state`=0.
- **AI first, player loses:** `p_first`=0, `p_slot`=2, `p_hp`=0 after ATTACK1 → `loss`=1 and `apply_ai_damage` never asserts that turn.
- **Turn limit:** `TURN_LIMIT_EN` with `MAX_TURNS`=3 and no faints → `draw`=1 after the third CHECK2, `turn_count`=3. Without the macro, turn 4 proceeds and `draw` stays 0.
